// File: rtl/uart_tx_fifo_if.sv
// Byte-write bus and status/serial outputs of the UART transmitter.
// The CPU side drives wr_en_i/wr_data_i and polls the status flags.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_AW = 4
);
  logic               wr_en_i;
  logic [7:0]         wr_data_i;
  logic               full_o;
  logic               empty_o;
  logic [FIFO_AW:0]   level_o;
  logic               busy_o;
  logic               ovf_o;
  logic               txd_o;

  modport master (
    output wr_en_i, wr_data_i,
    input  full_o, empty_o, level_o, busy_o, ovf_o, txd_o
  );

  modport slave (
    input  wr_en_i, wr_data_i,
    output full_o, empty_o, level_o, busy_o, ovf_o, txd_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter, 8N1, fed by a small byte FIFO. Each bit lasts
// CLK_FREQ_HZ / BAUD_RATE clocks; frames run back to back while data is queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_AW     = 4
) (
  input logic           clk_i,
  input logic           rst_n_i,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned      BitCycles = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned      Depth     = 2 ** FIFO_AW;
  localparam logic [31:0]      BitLast   = 32'(BitCycles - 1);
  localparam logic [FIFO_AW:0] LevelFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [31:0]          cnt_q;
  logic [2:0]           idx_q;
  logic [7:0]           shift_q;
  logic                 txd_q;
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;
  logic [FIFO_AW:0]     level_q;
  logic                 ovf_q;
  logic [7:0]           mem [Depth];

  logic       bit_done;
  logic       not_empty;
  logic       push;
  logic       pop;
  logic [7:0] head;

  // Pop decisions mirror the FSM transitions that load the shifter.
  always_comb begin
    bit_done  = (cnt_q == BitLast);
    not_empty = (level_q != '0);
    push      = bus.wr_en_i && (level_q != LevelFull);
    pop       = not_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
    head      = mem[rd_ptr_q];
  end

  // FIFO storage, no reset needed: only read when level says an entry is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.wr_data_i;
    end
  end

  // FIFO pointers, occupancy and overflow pulse; full is judged on the registered level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= bus.wr_en_i && (level_q == LevelFull);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Frame sequencer with registered serial output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          txd_q <= 1'b1;
          if (not_empty) begin
            shift_q <= head;
            idx_q   <= '0;
            txd_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            cnt_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StData: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= StStop;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StStop: begin
          if (bit_done) begin
            cnt_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (not_empty) begin
              shift_q <= head;
              idx_q   <= '0;
              txd_q   <= 1'b0;
              state_q <= StStart;
            end else begin
              txd_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          txd_q   <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Status outputs derive from registered state only.
  always_comb begin
    bus.full_o  = (level_q == LevelFull);
    bus.empty_o = (level_q == '0);
    bus.level_o = level_q;
    bus.busy_o  = (state_q != StIdle) || not_empty;
    bus.ovf_o   = ovf_q;
    bus.txd_o   = txd_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BIT_CYCLES = 10 (100-clock frames).
module tb_uart_tx_fifo;

  localparam int unsigned FifoAw = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;
  logic bad;

  logic [7:0] rx_q [$];
  int         rx_st_q [$];
  logic       rx_ok_q [$];

  logic [99:0] mon_s;
  int          mon_st;
  logic        mon_abort;
  logic        mon_ok;
  logic [7:0]  mon_b;

  uart_tx_fifo_if #(.FIFO_AW(FifoAw)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ_HZ(1152000),
    .BAUD_RATE  (115200),
    .FIFO_AW    (FifoAw)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rx_q.delete();
    rx_st_q.delete();
    rx_ok_q.delete();
  endtask

  // Serial line monitor: captures 100 samples per frame starting at the start bit,
  // requires every bit to be steady for its 10 clocks and the stop bit to be high.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.txd_o === 1'b0) begin
        mon_st    = cyc;
        mon_s     = '0;
        mon_abort = 1'b0;
        for (int i = 1; i < 100; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[i] = bus.txd_o;
        end
        if (!mon_abort) begin
          mon_ok = 1'b1;
          for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 10; j++) begin
              if (mon_s[10*b+j] !== mon_s[10*b]) mon_ok = 1'b0;
            end
          end
          if (mon_s[90] !== 1'b1) mon_ok = 1'b0;
          for (int k = 0; k < 8; k++) mon_b[k] = mon_s[10*(k+1)];
          rx_q.push_back(mon_b);
          rx_st_q.push_back(mon_st);
          rx_ok_q.push_back(mon_ok);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.wr_en_i   = 1'b0;
    bus.wr_data_i = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and a long quiet period.
    chk("rst_txd", bus.txd_o, 1);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_full", bus.full_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bus.txd_o !== 1'b1 || bus.empty_o !== 1'b1 || bus.level_o !== '0 ||
          bus.busy_o !== 1'b0) bad = 1'b1;
    end
    chk("idle_200", bad, 0);

    // Single byte 0x41: start bit one clock after the write edge.
    clr();
    @(negedge clk); bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h41;
    @(negedge clk); bus.wr_en_i = 1'b0; t0 = cyc;
    chk("a_lvl_after_wr", bus.level_o, 1);
    chk("a_txd_before_start", bus.txd_o, 1);
    chk("a_busy", bus.busy_o, 1);
    @(negedge clk);
    chk("a_txd_start", bus.txd_o, 0);
    chk("a_lvl_popped", bus.level_o, 0);
    chk("a_busy_frame", bus.busy_o, 1);
    repeat (99) @(negedge clk);
    chk("a_stop_txd", bus.txd_o, 1);
    chk("a_stop_busy", bus.busy_o, 1);
    @(negedge clk);
    chk("a_idle_busy", bus.busy_o, 0);
    chk("a_idle_txd", bus.txd_o, 1);
    chk("a_frames", rx_q.size(), 1);
    chk("a_data", rx_q[0], 8'h41);
    chk("a_shape", rx_ok_q[0], 1);
    chk("a_start_time", rx_st_q[0], t0 + 1);

    // Three consecutive writes: contiguous frames, level 1,1,2 then pops at STOP->START.
    clr();
    @(negedge clk); bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h48;
    @(negedge clk); t0 = cyc;
    chk("b_lvl0", bus.level_o, 1);
    bus.wr_data_i = 8'h69;
    @(negedge clk);
    chk("b_lvl1", bus.level_o, 1);
    chk("b_txd_start", bus.txd_o, 0);
    bus.wr_data_i = 8'h0A;
    @(negedge clk);
    chk("b_lvl2", bus.level_o, 2);
    bus.wr_en_i = 1'b0;
    repeat (98) @(negedge clk);
    chk("b_lvl_before_pop", bus.level_o, 2);
    @(negedge clk);
    chk("b_lvl_after_pop1", bus.level_o, 1);
    repeat (100) @(negedge clk);
    chk("b_lvl_after_pop2", bus.level_o, 0);
    repeat (100) @(negedge clk);
    chk("b_busy_end", bus.busy_o, 0);
    chk("b_frames", rx_q.size(), 3);
    chk("b_data0", rx_q[0], 8'h48);
    chk("b_data1", rx_q[1], 8'h69);
    chk("b_data2", rx_q[2], 8'h0A);
    chk("b_shape", {29'd0, rx_ok_q[0], rx_ok_q[1], rx_ok_q[2]}, 32'h7);
    chk("b_start0", rx_st_q[0], t0 + 1);
    chk("b_gap01", rx_st_q[1] - rx_st_q[0], 100);
    chk("b_gap12", rx_st_q[2] - rx_st_q[1], 100);

    // 17 writes fill the FIFO after the first pop; 0xFF overflows and is dropped.
    clr();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); bus.wr_en_i = 1'b1; bus.wr_data_i = 8'(i);
    end
    @(negedge clk);
    chk("c_full", bus.full_o, 1);
    chk("c_lvl16", bus.level_o, 16);
    chk("c_no_ovf_yet", bus.ovf_o, 0);
    bus.wr_data_i = 8'hFF;
    @(negedge clk);
    chk("c_ovf_pulse", bus.ovf_o, 1);
    chk("c_lvl_kept", bus.level_o, 16);
    bus.wr_en_i = 1'b0;
    @(negedge clk);
    chk("c_ovf_clear", bus.ovf_o, 0);
    chk("c_still_full", bus.full_o, 1);
    repeat (1700) @(negedge clk);
    chk("c_frames", rx_q.size(), 17);
    bad = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (rx_q[i] !== 8'(i) || rx_ok_q[i] !== 1'b1) bad = 1'b1;
    end
    chk("c_order", bad, 0);
    chk("c_busy_end", bus.busy_o, 0);
    chk("c_empty_end", bus.empty_o, 1);

    // Asynchronous reset during data bit 3 of 0x55 with two bytes queued.
    clr();
    @(negedge clk); bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h55;
    @(negedge clk); t0 = cyc; bus.wr_data_i = 8'hAA;
    @(negedge clk); bus.wr_data_i = 8'hCC;
    @(negedge clk); bus.wr_en_i = 1'b0;
    repeat (43) @(negedge clk);
    chk("d_bit3", bus.txd_o, 0);
    chk("d_lvl_queued", bus.level_o, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("d_txd_async", bus.txd_o, 1);
    chk("d_lvl_async", bus.level_o, 0);
    chk("d_empty_async", bus.empty_o, 1);
    chk("d_busy_async", bus.busy_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.txd_o !== 1'b1 || bus.level_o !== '0 || bus.busy_o !== 1'b0) bad = 1'b1;
    end
    chk("d_quiet_after_rst", bad, 0);
    chk("d_frames", rx_q.size(), 0);

    // Two back-to-back frames 0x1B, 0x04.
    clr();
    @(negedge clk); bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h1B;
    @(negedge clk); t0 = cyc; bus.wr_data_i = 8'h04;
    @(negedge clk); bus.wr_en_i = 1'b0;
    repeat (205) @(negedge clk);
    chk("e_frames", rx_q.size(), 2);
    chk("e_data0", rx_q[0], 8'h1B);
    chk("e_data1", rx_q[1], 8'h04);
    chk("e_shape", {30'd0, rx_ok_q[0], rx_ok_q[1]}, 32'h3);
    chk("e_start0", rx_st_q[0], t0 + 1);
    chk("e_gap", rx_st_q[1] - rx_st_q[0], 100);
    chk("e_busy_end", bus.busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Synthesizable UART transmitter inside the core's peripheral block.
- Directly upstream of the simulation UART monitor: its `txd_o` drives the monitor's serial input.
- CPU store path writes bytes into a small TX FIFO. The block serializes each byte as 8N1 (start=0, 8 data bits LSB first, stop=1) at a fixed baud rate derived from the crystal frequency.

Parameters:
- CLK_FREQ_HZ, 50000000, core clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (16).

Ports:
- clk_i  input  1  core clock, all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- wr_en_i  input  1  one-cycle write strobe from the bus decoder.
- wr_data_i  input  8  byte to transmit, sampled when wr_en_i=1.
- full_o  output  1  FIFO holds 2**FIFO_AW entries.
- empty_o  output  1  FIFO holds 0 entries.
- level_o  output  FIFO_AW+1  current FIFO occupancy.
- busy_o  output  1  shifter not IDLE, or FIFO non-empty.
- ovf_o  output  1  one-cycle pulse, a write was dropped because FIFO full.
- txd_o  output  1  serial line, idles high.

Behaviour:
- BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE (integer truncation, constant). Every bit, including start and stop, is held for exactly BIT_CYCLES clocks. Frame = 10*BIT_CYCLES clocks.
- Reset (async, asserted at any time, including mid-frame):
  - txd_o=1, FSM=IDLE, FIFO pointers/level=0.
  - empty_o=1, full_o=0, busy_o=0, ovf_o=0, baud counter=0.
  - Any in-flight byte and all queued bytes are discarded.
- FIFO:
  - Registered read/write pointers, FIFO_AW bits each, wrap modulo depth.
  - Level counter is FIFO_AW+1 bits.
  - Write accepted when wr_en_i=1 and level < depth.
  - Write while full: data dropped, level unchanged, ovf_o=1 for that following cycle only. This applies even if a pop happens the same cycle; full is evaluated on the registered level.
  - Simultaneous accepted write and pop: level unchanged, both pointers advance.
  - full_o/empty_o/level_o are registered and reflect the level after the edge.
- FSM states IDLE, START, DATA, STOP; txd_o is a registered output.
  - IDLE: txd_o=1. If FIFO non-empty: pop head into shift register, bit index=0, baud counter=0, go to START.
  - START: txd_o=0. When baud counter reaches BIT_CYCLES-1, reset counter and go to DATA.
  - DATA: txd_o=shift[0]. At BIT_CYCLES-1: shift right, increment index. After index 7 completes, go to STOP.
  - STOP: txd_o=1. At BIT_CYCLES-1: if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Latency: a byte written into an empty FIFO while IDLE at edge N is popped at edge N+1. txd_o falls at edge N+1 (start bit begins one clock after the write edge).
- busy_o = (state != IDLE) | ~empty.
- Baud counter counts only in START/DATA/STOP and is held at 0 in IDLE. Its width is sufficient for BIT_CYCLES-1 (32 bits max).
- The block performs no flow control toward the line; software polls full_o/busy_o.

Test Plan:
- Sim with CLK_FREQ_HZ=1152000, BAUD_RATE=115200 (BIT_CYCLES=10).
- Reset release, no writes -> txd_o=1, empty_o=1, level_o=0, busy_o=0 for 200 clocks.
- Write 0x41 at edge N -> txd_o=0 over edges N+1..N+10; then bits 1,0,0,0,0,0,1,0 at 10 clocks each; stop=1 through N+100; then IDLE, busy_o=0.
- Write 0x48,0x69,0x0A on consecutive cycles -> three contiguous frames, 300 clocks total, no idle gap; level_o goes 1,1,2 then decrements at each STOP->START pop.
- 17 back-to-back writes (0x00..0x10) while IDLE -> first byte popped immediately; remaining 16 fill the FIFO and full_o=1; then write 0xFF -> ovf_o pulses once, 0xFF never transmitted; 17 frames observed in order 0x00..0x10.
- Assert rst_n_i during bit 3 of frame 0x55 with 2 queued bytes -> txd_o=1 immediately (asynchronous); after release no further frames, level_o=0.
- Write 0x1B then 0x04 -> two contiguous frames with exact bit patterns; downstream monitor reports simulation end.
